prom_loader: RTL
================

Name: prom_loader

Overview:
Framed program loader between the UART receiver and the instruction PROM.
- Accepts a sync/length/payload/checksum frame over UART and writes 16-bit words into the PROM.
- Holds the CPU in reset until a frame has been fully received and its checksum verified.
- Replaces the free-running low/high byte filler with a validated, restartable load sequence.

Parameters:
- ROM_WORDS, 8, PROM depth in 16-bit words; address width AW = max(1, clog2(ROM_WORDS)).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 625, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data_i  input  8  received UART byte.
- rx_ready_i  input  1  byte valid; one byte is consumed per clk edge where rx_ready_i=1.
- rx_ack_o  output  1  acknowledge to UART; equals rx_ready_i when reset=0, 0 during reset.
- prom_we_o  output  1  one-cycle PROM write strobe.
- prom_addr_o  output  AW  PROM word address.
- prom_data_o  output  16  PROM write data {hi, lo}.
- cpu_reset_o  output  1  CPU reset; 1 = CPU held in reset.
- done_o  output  1  program loaded and verified; CPU running.
- error_o  output  1  last frame rejected.

Behaviour:
- Reset state: state=IDLE, prom_we_o=0, prom_addr_o=0, prom_data_o=0, cpu_reset_o=1, done_o=0, error_o=0, word count, index and checksum accumulator all 0. All outputs are registered except rx_ack_o.
- Frame format: SYNC_BYTE, N, then N words each sent low byte then high byte, then CK.
  - CK = XOR of N and all 2N payload bytes.
- IDLE: a byte equal to SYNC_BYTE moves to LEN; any other byte is discarded.
- LEN:
  - N=0 or N>ROM_WORDS moves to ERROR.
  - Otherwise store N, index=0, csum=N, and move to LO.
- LO: latch the low byte, csum ^= byte, move to HI.
- HI:
  - csum ^= byte.
  - On the next cycle: prom_we_o=1 for exactly one cycle, prom_addr_o=index, prom_data_o={byte, lo}.
  - index increments. If index+1==N move to CSUM, else back to LO.
  - Write latency is 1 clk after the HI byte is accepted.
- CSUM:
  - Byte == csum: move to RUN; cpu_reset_o=0 and done_o=1 from the next cycle.
  - Byte != csum: move to ERROR; error_o=1 and cpu_reset_o stays 1.
- RUN: a SYNC_BYTE reasserts cpu_reset_o=1 and clears done_o on the next cycle, then moves to LEN. Other bytes are ignored.
- ERROR: a SYNC_BYTE clears error_o and moves to LEN. Other bytes are ignored.
- Entering LEN from any state clears error_o and done_o.
- Words already written by a rejected frame stay in the PROM. The CPU never runs them because cpu_reset_o remains 1.
- prom_addr_o and prom_data_o hold their last values when prom_we_o=0.
- Payload-phase bytes (LO/HI/CSUM) equal to SYNC_BYTE are treated as data, not as a restart.
- Asynchronous reset mid-frame: returns to the reset state immediately. An in-flight prom_we_o is dropped in the same instant, and the partial frame is discarded.

Optional Feature:
- PROM_LOADER_TIMEOUT_EN defined:
  - A cycle counter clears on every accepted byte and on entry to LEN.
  - It counts while in LEN, LO, HI or CSUM.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, the next cycle enters ERROR with error_o=1 and cpu_reset_o=1.
  - The counter is held at 0 in IDLE, RUN and ERROR.
- PROM_LOADER_TIMEOUT_EN undefined: no counter; the block waits indefinitely in every state.

Test Plan:
1. Good frame: bytes A5,02,34,12,CD,AB,42 -> writes addr0=16'h1234 and addr1=16'hABCD, one prom_we_o pulse each. One cycle after 42 is accepted: cpu_reset_o=0, done_o=1, error_o=0.
2. Bad checksum: same frame with CK=43 -> both words written, then error_o=1, cpu_reset_o=1, done_o=0. A following good frame clears error_o and ends with done_o=1.
3. Bad length, ROM_WORDS=8: A5,00 and A5,09 -> ERROR after the length byte, no prom_we_o pulse, error_o=1.
4. Reload while running: after scenario 1, send A5 -> next cycle cpu_reset_o=1, done_o=0. Then 01,FF,00,FE loads addr0=16'h00FF and returns to RUN (CK = 01^FF^00 = FE).
5. Noise and async reset: bytes 11,22 in IDLE -> ignored. Then A5,02,34 followed by reset mid-frame -> all outputs return to reset values and the next frame loads cleanly.
6. With PROM_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=625: A5,02,34 then 625 idle cycles -> error_o=1, cpu_reset_o=1, and no write for the partial word.

Source files
------------

// File: rtl/prom_loader_if.sv
// UART-receive and PROM-write bus shared by the program loader and its environment.
interface prom_loader_if #(
  parameter int unsigned ROM_WORDS = 8
);
  localparam int unsigned AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;

  logic [7:0]    rx_data_i;
  logic          rx_ready_i;
  logic          rx_ack_o;
  logic          prom_we_o;
  logic [AW-1:0] prom_addr_o;
  logic [15:0]   prom_data_o;
  logic          cpu_reset_o;
  logic          done_o;
  logic          error_o;

  modport slave (
    input  rx_data_i, rx_ready_i,
    output rx_ack_o, prom_we_o, prom_addr_o, prom_data_o, cpu_reset_o, done_o, error_o
  );

  modport master (
    output rx_data_i, rx_ready_i,
    input  rx_ack_o, prom_we_o, prom_addr_o, prom_data_o, cpu_reset_o, done_o, error_o
  );
endinterface

// File: rtl/prom_loader.sv
// Framed PROM loader: SYNC, N, N little-endian words, XOR checksum; releases the CPU only after a verified frame.
// Optional inter-byte timeout enabled by defining PROM_LOADER_TIMEOUT_EN.
module prom_loader #(
  parameter int unsigned ROM_WORDS      = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 625
) (
  input  logic          clk,
  input  logic          reset,
  prom_loader_if.slave  bus
);
  localparam int unsigned AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
  localparam int unsigned NW = $clog2(ROM_WORDS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic [2:0]    r_state,     w_state;
  logic [NW-1:0] r_n,         w_n;
  logic [AW-1:0] r_idx,       w_idx;
  logic [7:0]    r_csum,      w_csum;
  logic [7:0]    r_lo,        w_lo;
  logic          r_we,        w_we;
  logic [AW-1:0] r_addr,      w_addr;
  logic [15:0]   r_data,      w_data;
  logic          r_cpu_reset, w_cpu_reset;
  logic          r_done,      w_done;
  logic          r_error,     w_error;

  logic w_byte;
  logic w_sync;
  logic w_len_bad;
  logic w_last;

  assign w_byte    = bus.rx_ready_i;
  assign w_sync    = w_byte && (bus.rx_data_i == SYNC_BYTE);
  assign w_len_bad = (bus.rx_data_i == 8'd0) || (32'(bus.rx_data_i) > ROM_WORDS);
  assign w_last    = ((NW'(r_idx) + NW'(1)) == r_n);

`ifdef PROM_LOADER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo, w_tmo;
`endif

  // Next-state and registered-output logic
  always_comb begin
    w_state     = r_state;
    w_n         = r_n;
    w_idx       = r_idx;
    w_csum      = r_csum;
    w_lo        = r_lo;
    w_we        = 1'b0;
    w_addr      = r_addr;
    w_data      = r_data;
    w_cpu_reset = r_cpu_reset;
    w_done      = r_done;
    w_error     = r_error;

    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (w_sync) begin
          w_state     = S_LEN;
          w_cpu_reset = 1'b1;
          w_done      = 1'b0;
          w_error     = 1'b0;
        end
      end
      S_LEN: begin
        if (w_byte) begin
          if (w_len_bad) begin
            w_state = S_ERROR;
            w_error = 1'b1;
          end else begin
            w_state = S_LO;
            w_n     = NW'(bus.rx_data_i);
            w_idx   = '0;
            w_csum  = bus.rx_data_i;
          end
        end
      end
      S_LO: begin
        if (w_byte) begin
          w_lo    = bus.rx_data_i;
          w_csum  = r_csum ^ bus.rx_data_i;
          w_state = S_HI;
        end
      end
      S_HI: begin
        if (w_byte) begin
          w_csum  = r_csum ^ bus.rx_data_i;
          w_we    = 1'b1;
          w_addr  = r_idx;
          w_data  = {bus.rx_data_i, r_lo};
          w_idx   = r_idx + AW'(1);
          w_state = w_last ? S_CSUM : S_LO;
        end
      end
      S_CSUM: begin
        if (w_byte) begin
          if (bus.rx_data_i == r_csum) begin
            w_state     = S_RUN;
            w_cpu_reset = 1'b0;
            w_done      = 1'b1;
          end else begin
            w_state = S_ERROR;
            w_error = 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase

`ifdef PROM_LOADER_TIMEOUT_EN
    // A stalled frame is abandoned; the CPU stays held in reset
    w_tmo = '0;
    if ((r_state == S_LEN) || (r_state == S_LO) || (r_state == S_HI) || (r_state == S_CSUM)) begin
      if (w_byte) begin
        w_tmo = '0;
      end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        w_state     = S_ERROR;
        w_error     = 1'b1;
        w_cpu_reset = 1'b1;
        w_done      = 1'b0;
      end else begin
        w_tmo = r_tmo + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_idx       <= '0;
      r_csum      <= '0;
      r_lo        <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_n         <= w_n;
      r_idx       <= w_idx;
      r_csum      <= w_csum;
      r_lo        <= w_lo;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_cpu_reset <= w_cpu_reset;
      r_done      <= w_done;
      r_error     <= w_error;
    end
  end

`ifdef PROM_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tmo <= '0;
    else       r_tmo <= w_tmo;
  end
`endif

  assign bus.rx_ack_o    = bus.rx_ready_i & ~reset;
  assign bus.prom_we_o   = r_we;
  assign bus.prom_addr_o = r_addr;
  assign bus.prom_data_o = r_data;
  assign bus.cpu_reset_o = r_cpu_reset;
  assign bus.done_o      = r_done;
  assign bus.error_o     = r_error;
endmodule
